// File: rtl/x_mux_trigger_pkg.sv
// Shared types and default widths for the mux-trigger tap sweep.
// Tap field sits at the bottom of the ctrl word, as the delay-line core expects.
package x_mux_trigger_pkg;

    localparam int P_TAP_W_DEF = 8;
    localparam int P_CNT_W_DEF = 16;
    localparam int P_SET_W_DEF = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_SETTLE,
        S_SAMPLE,
        S_DRAIN,
        S_REPORT,
        S_DONE
    } t_sweep_state;

endpackage

// File: rtl/x_sat_counter.sv
// Clearable up-counter that sticks at all-ones instead of wrapping.
module x_sat_counter #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_cnt <= '0;
        end else if (i_clr) begin
            o_cnt <= '0;
        end else if (i_inc && (o_cnt != '1)) begin
            o_cnt <= o_cnt + W'(1);
        end
    end

endmodule

// File: rtl/x_mux_trigger_sweep.sv
// Tap-sweep scheduler: steps the delay-line tap, settles, samples,
// counts mask hits and hands one result per tap over valid/ready.
module x_mux_trigger_sweep
    import x_mux_trigger_pkg::*;
#(
    parameter int P_TAP_W = P_TAP_W_DEF,
    parameter int P_CNT_W = P_CNT_W_DEF,
    parameter int P_SET_W = P_SET_W_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic [P_TAP_W-1:0] i_tap_first,
    input  logic [P_TAP_W-1:0] i_tap_last,
    input  logic [31:0]        i_ctrl_base,
    input  logic [P_SET_W-1:0] i_settle,
    input  logic [P_CNT_W-1:0] i_samples,
    input  logic [31:0]        i_mask,
    output logic [31:0]        o_ctrl,
    input  logic [31:0]        i_data,
    output logic               o_res_valid,
    input  logic               i_res_ready,
    output logic [P_TAP_W-1:0] o_res_tap,
    output logic [P_CNT_W-1:0] o_res_hits,
    output logic               o_busy,
    output logic               o_done
);

    t_sweep_state state_q, state_d;

    logic [P_TAP_W-1:0]  first_q;
    logic [P_TAP_W-1:0]  last_q;
    logic [P_TAP_W-1:0]  tap_q;
    logic [31-P_TAP_W:0] base_q;
    logic [P_SET_W-1:0]  settle_q;
    logic [P_SET_W-1:0]  set_cnt_q;
    logic [P_CNT_W-1:0]  n_q;
    logic [P_CNT_W-1:0]  smp_cnt_q;
    logic [31:0]         mask_q;
    logic [31:0]         data_q;
    logic                up_q;
    logic                smp_vld_q;

    logic start_ok;
    logic xfer;
    logic last_tap;
    logic hit;
    logic hit_clr;
    logic unused_base_lo;

    assign unused_base_lo = ^{i_ctrl_base[P_TAP_W-1:0], first_q};

    assign start_ok    = (state_q == S_IDLE) && i_start && !i_abort;
    assign o_res_valid = (state_q == S_REPORT) && !i_abort;
    assign xfer        = o_res_valid && i_res_ready;
    assign last_tap    = (tap_q == last_q);
    assign hit_clr     = (state_q == S_APPLY);
    // Hit test runs on the registered sample, one cycle behind SAMPLE.
    assign hit         = smp_vld_q && |(data_q & mask_q);

    assign o_busy    = (state_q != S_IDLE);
    assign o_done    = (state_q == S_DONE);
    assign o_res_tap = tap_q;

    x_sat_counter #(
        .W(P_CNT_W)
    ) u_hits (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_clr  (hit_clr),
        .i_inc  (hit),
        .o_cnt  (o_res_hits)
    );

    always_comb begin
        state_d = state_q;
        if (i_abort) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE:   if (i_start) state_d = S_APPLY;
                S_APPLY:  state_d = (settle_q == '0) ? S_SAMPLE : S_SETTLE;
                S_SETTLE: if (set_cnt_q == P_SET_W'(1)) state_d = S_SAMPLE;
                S_SAMPLE: if (smp_cnt_q == n_q - P_CNT_W'(1)) state_d = S_DRAIN;
                S_DRAIN:  state_d = S_REPORT;
                S_REPORT: if (xfer) state_d = last_tap ? S_DONE : S_APPLY;
                S_DONE:   state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            first_q   <= '0;
            last_q    <= '0;
            tap_q     <= '0;
            base_q    <= '0;
            settle_q  <= '0;
            set_cnt_q <= '0;
            n_q       <= '0;
            smp_cnt_q <= '0;
            mask_q    <= '0;
            data_q    <= '0;
            up_q      <= 1'b0;
            smp_vld_q <= 1'b0;
            o_ctrl    <= '0;
        end else begin
            state_q   <= state_d;
            smp_vld_q <= (state_q == S_SAMPLE) && !i_abort;
            if (state_q == S_SAMPLE) data_q <= i_data;
            if (start_ok) begin
                first_q  <= i_tap_first;
                last_q   <= i_tap_last;
                tap_q    <= i_tap_first;
                base_q   <= i_ctrl_base[31:P_TAP_W];
                settle_q <= i_settle;
                mask_q   <= i_mask;
                up_q     <= (i_tap_first <= i_tap_last);
                n_q      <= (i_samples == '0) ? P_CNT_W'(1) : i_samples;
            end
            if (state_q == S_APPLY && !i_abort) begin
                o_ctrl    <= {base_q, tap_q};
                set_cnt_q <= settle_q;
                smp_cnt_q <= '0;
            end
            if (state_q == S_SETTLE) set_cnt_q <= set_cnt_q - P_SET_W'(1);
            if (state_q == S_SAMPLE) smp_cnt_q <= smp_cnt_q + P_CNT_W'(1);
            // Last-tap check precedes stepping, so the tap never wraps.
            if (xfer && !last_tap) begin
                tap_q <= up_q ? tap_q + P_TAP_W'(1) : tap_q - P_TAP_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_x_mux_trigger_sweep.sv
// Scoreboard bench for the tap-sweep scheduler.
// Stimulus pushes expected results; a negedge monitor pops on transfer.
module tb_x_mux_trigger_sweep;

    localparam int TW = 8;
    localparam int CW = 4;
    localparam int SW = 8;
    localparam logic [31:0] BASE = 32'hDEAD_BE77;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_start = 1'b0;
    logic          i_abort = 1'b0;
    logic [TW-1:0] i_tap_first = '0;
    logic [TW-1:0] i_tap_last = '0;
    logic [31:0]   i_ctrl_base = BASE;
    logic [SW-1:0] i_settle = '0;
    logic [CW-1:0] i_samples = '0;
    logic [31:0]   i_mask = '0;
    logic [31:0]   o_ctrl;
    logic [31:0]   i_data = '0;
    logic          o_res_valid;
    logic          i_res_ready = 1'b1;
    logic [TW-1:0] o_res_tap;
    logic [CW-1:0] o_res_hits;
    logic          o_busy;
    logic          o_done;

    logic alt = 1'b0;

    typedef struct packed {
        logic [TW-1:0] tap;
        logic [CW-1:0] hits;
        logic [31:0]   ctrl;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_done = 0;

    x_mux_trigger_sweep #(
        .P_TAP_W(TW),
        .P_CNT_W(CW),
        .P_SET_W(SW)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (i_start),
        .i_abort    (i_abort),
        .i_tap_first(i_tap_first),
        .i_tap_last (i_tap_last),
        .i_ctrl_base(i_ctrl_base),
        .i_settle   (i_settle),
        .i_samples  (i_samples),
        .i_mask     (i_mask),
        .o_ctrl     (o_ctrl),
        .i_data     (i_data),
        .o_res_valid(o_res_valid),
        .i_res_ready(i_res_ready),
        .o_res_tap  (o_res_tap),
        .o_res_hits (o_res_hits),
        .o_busy     (o_busy),
        .o_done     (o_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (alt) begin
            #1;
            i_data = {31'b0, ~i_data[0]};
        end
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_ctrl(input logic [TW-1:0] tap);
        return {BASE[31:TW], tap};
    endfunction

    always @(negedge clk) begin
        if (o_done) n_done++;
        if (o_res_valid) begin
            if (sb.size() == 0) begin
                if (i_res_ready) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_result: tap=%0d hits=%0d",
                             o_res_tap, o_res_hits);
                end
            end else begin
                m_e = sb[0];
                check("res_tap", 64'(o_res_tap), 64'(m_e.tap));
                check("res_hits", 64'(o_res_hits), 64'(m_e.hits));
                check("res_ctrl", 64'(o_ctrl), 64'(m_e.ctrl));
                if (i_res_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic cfg(input int first, input int last, input int settle,
                       input int n, input logic [31:0] mask);
        i_tap_first = TW'(first);
        i_tap_last  = TW'(last);
        i_settle    = SW'(settle);
        i_samples   = CW'(n);
        i_mask      = mask;
    endtask

    task automatic push_sweep(input int first, input int last, input int hits);
        int t;
        t = first;
        forever begin
            sb.push_back('{tap: TW'(t), hits: CW'(hits), ctrl: exp_ctrl(TW'(t))});
            if (t == last) break;
            t += (first <= last) ? 1 : -1;
        end
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 i_start = 1'b1;
        @(posedge clk);
        #1 i_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input int d0);
        int k;
        for (k = 0; k < budget; k++) begin
            @(posedge clk);
            if (n_done > d0) break;
        end
        check("done_count", 64'(n_done - d0), 64'd1);
        check("queue_empty", 64'(sb.size()), 64'd0);
        @(negedge clk);
        check("idle_busy", 64'(o_busy), 64'd0);
    endtask

    task automatic wait_valid(input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(posedge clk);
            #1;
            if (o_res_valid) break;
        end
        check("valid_seen", 64'(o_res_valid), 64'd1);
    endtask

    task automatic run(input int budget);
        int d0;
        d0 = n_done;
        pulse_start();
        wait_done(budget, d0);
    endtask

    initial begin
        int d0;
        int lat;

        #1;
        check("rst_ctrl", 64'(o_ctrl), 64'd0);
        check("rst_valid", 64'(o_res_valid), 64'd0);
        check("rst_tap", 64'(o_res_tap), 64'd0);
        check("rst_hits", 64'(o_res_hits), 64'd0);
        check("rst_busy", 64'(o_busy), 64'd0);
        check("rst_done", 64'(o_done), 64'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Up sweep, first-result latency, start ignored while busy
        cfg(3, 5, 2, 4, 32'h1);
        i_data = 32'h1;
        push_sweep(3, 5, 4);
        d0 = n_done;
        pulse_start();
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!o_res_valid && lat < 100);
        check("first_latency", 64'(lat), 64'd9);
        cfg(9, 9, 0, 1, 32'h0);
        pulse_start();
        wait_done(300, d0);

        // Down sweep with alternating data
        cfg(5, 3, 0, 8, 32'h1);
        alt = 1'b1;
        push_sweep(5, 3, 4);
        run(300);
        alt = 1'b0;
        #2 i_data = 32'h1;

        // Backpressure: 20 stalled cycles
        cfg(7, 7, 1, 3, 32'h1);
        i_res_ready = 1'b0;
        push_sweep(7, 7, 3);
        d0 = n_done;
        pulse_start();
        wait_valid(100);
        repeat (20) @(negedge clk);
        @(posedge clk);
        #1 i_res_ready = 1'b1;
        wait_done(100, d0);

        // Max samples and the zero-sample case
        cfg(9, 9, 0, 15, 32'h1);
        push_sweep(9, 9, 15);
        run(100);
        cfg(9, 9, 0, 0, 32'h1);
        push_sweep(9, 9, 1);
        run(100);

        // Abort during SETTLE, with a same-cycle start
        cfg(2, 4, 10, 4, 32'h1);
        d0 = n_done;
        pulse_start();
        repeat (3) @(posedge clk);
        #1;
        i_abort = 1'b1;
        i_start = 1'b1;
        @(posedge clk);
        #1;
        i_abort = 1'b0;
        i_start = 1'b0;
        check("abort_settle_busy", 64'(o_busy), 64'd0);
        check("abort_settle_valid", 64'(o_res_valid), 64'd0);
        check("abort_settle_ctrl", 64'(o_ctrl), 64'(exp_ctrl(8'd2)));
        repeat (3) @(posedge clk);
        #1;
        check("abort_settle_stay", 64'(o_busy), 64'd0);
        check("abort_settle_done", 64'(n_done - d0), 64'd0);

        // Abort on a REPORT transfer cycle, then restart
        cfg(2, 4, 0, 2, 32'h1);
        i_res_ready = 1'b0;
        d0 = n_done;
        pulse_start();
        wait_valid(100);
        i_abort = 1'b1;
        i_res_ready = 1'b1;
        @(posedge clk);
        #1 i_abort = 1'b0;
        check("abort_rep_busy", 64'(o_busy), 64'd0);
        check("abort_rep_valid", 64'(o_res_valid), 64'd0);
        check("abort_rep_ctrl", 64'(o_ctrl), 64'(exp_ctrl(8'd2)));
        @(negedge clk);
        check("abort_rep_done", 64'(n_done - d0), 64'd0);
        push_sweep(2, 4, 2);
        run(300);

        // Async reset mid-SAMPLE
        cfg(1, 2, 0, 15, 32'h1);
        pulse_start();
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ctrl", 64'(o_ctrl), 64'd0);
        check("arst_valid", 64'(o_res_valid), 64'd0);
        check("arst_tap", 64'(o_res_tap), 64'd0);
        check("arst_hits", 64'(o_res_hits), 64'd0);
        check("arst_busy", 64'(o_busy), 64'd0);
        check("arst_done", 64'(o_done), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        cfg(6, 6, 1, 2, 32'h1);
        push_sweep(6, 6, 2);
        run(100);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
